// File: rtl/cpu_io_pkg.sv
// Shared constants for CPU-side serial/parallel I/O blocks.
// Defines the serial word width, status field offsets and ser lane IDs.
package cpu_io_pkg;

    localparam int SER_WIDTH  = 32;

    // Status word layout: [15]=ovf, [14]=unf, [AW:0]=level,
    // bit index (6 bits) directly above level, zero padding above that.
    localparam int STATUS_W   = 16;
    localparam int STATUS_OVF = 15;
    localparam int STATUS_UNF = 14;
    localparam int STATUS_BIW = 6;

    typedef enum logic [1:0] {
        SER_LANE0 = 2'd0,
        SER_LANE1 = 2'd1,
        SER_LANE2 = 2'd2
    } ser_lane_e;

    function automatic int status_pad_w(input int aw);
        return STATUS_W - 2 - STATUS_BIW - (aw + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// Pointer, count and registered full/empty logic for a synchronous FIFO.
// Ports: clk, rst, clear, push, pop in; push_ok, pointers, count, flags out.
module sync_fifo_ptr #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    output logic          push_ok,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] rd_ptr,
    output logic [AW-1:0] rd_ptr_nxt,
    output logic [AW:0]   count,
    output logic [AW:0]   count_nxt,
    output logic          full,
    output logic          empty
);

    logic          pop_ok;
    logic [AW-1:0] wr_ptr_nxt;

    // A push into a full FIFO is still accepted when a pop frees the
    // head slot in the same cycle.
    assign pop_ok  = pop && !empty && !clear;
    assign push_ok = push && (!full || pop_ok) && !clear;

    always_comb begin
        wr_ptr_nxt = wr_ptr + AW'(push_ok);
        rd_ptr_nxt = rd_ptr + AW'(pop_ok);
        count_nxt  = count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        if (clear) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            full   <= (count_nxt == (AW+1)'(DEPTH));
            empty  <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/cpu_ser_fifo.sv
// Word-to-bit serial FIFO feeding one CPU ser[] lane, MSB first by default.
// Ports: wr_en/wr_data/full push side; rd_bit/ser/flush/empty CPU side;
// level, status, ovf, unf readback. Macro CPU_SER_FIFO_LSB_FIRST_EN
// switches bit order to LSB first.
module cpu_ser_fifo
    import cpu_io_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = SER_WIDTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_bit,
    output logic             ser,
    input  logic             flush,
    output logic             empty,
    output logic [AW:0]      level,
    output logic [15:0]      status,
    output logic             ovf,
    output logic             unf
);

    localparam int BW   = $clog2(WIDTH);
    localparam int PADW = status_pad_w(AW);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [BW-1:0]    bit_idx;
    logic [BW-1:0]    bit_nxt;
    logic             pop_bit;
    logic             word_pop;
    logic             push_ok;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             bypass;
    logic [WIDTH-1:0] head_nxt;
    logic             ser_nxt;

    assign pop_bit  = rd_bit && !empty && !flush;
    assign word_pop = pop_bit && (bit_idx == BW'(WIDTH-1));

    sync_fifo_ptr #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_ptr (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (wr_en),
        .pop       (word_pop),
        .push_ok   (push_ok),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .rd_ptr_nxt(rd_ptr_nxt),
        .count     (count),
        .count_nxt (count_nxt),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        bit_nxt = bit_idx;
        if (flush) begin
            bit_nxt = '0;
        end else if (word_pop) begin
            bit_nxt = '0;
        end else if (pop_bit) begin
            bit_nxt = bit_idx + BW'(1);
        end
    end

    // When the word being written becomes the new head this cycle the
    // array has not been updated yet, so take it straight from wr_data.
    assign bypass   = push_ok &&
                      ((count - (AW+1)'(word_pop)) == '0);
    assign head_nxt = bypass ? wr_data : mem[rd_ptr_nxt];

    always_comb begin
        ser_nxt = 1'b0;
        if (count_nxt != '0) begin
`ifdef CPU_SER_FIFO_LSB_FIRST_EN
            ser_nxt = head_nxt[bit_nxt];
`else
            ser_nxt = head_nxt[BW'(WIDTH-1) - bit_nxt];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx <= '0;
            ser     <= 1'b0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
        end else begin
            bit_idx <= bit_nxt;
            ser     <= ser_nxt;
            if (flush) begin
                ovf <= 1'b0;
                unf <= 1'b0;
            end else begin
                ovf <= ovf | (wr_en && !push_ok);
                unf <= unf | (rd_bit && empty);
            end
        end
    end

    assign level  = count;
    assign status = {ovf, unf, {PADW{1'b0}},
                     STATUS_BIW'(bit_idx), count};

endmodule
